// File: rtl/mru_pkg.sv
// mru_pkg: shared types and helpers for the button MRU history blocks
package mru_pkg;
    localparam int MRU_NUM_BTN = 4;
    typedef logic [1:0] btn_id_t;
    typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} replay_state_t;
    function automatic logic [MRU_NUM_BTN-1:0] id2led(btn_id_t id);
        return MRU_NUM_BTN'(1) << id;
    endfunction
endpackage

// File: rtl/mru_replay_if.sv
// mru_replay_if: button push / replay request side and LED/status side of mru_replay
interface mru_replay_if import mru_pkg::*; #(parameter int DEPTH = 3);
    logic push_valid;
    btn_id_t push_id;
    logic replay_req;
    logic busy;
    logic done;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [MRU_NUM_BTN-1:0] l;
    modport master (output push_valid, push_id, replay_req, input busy, done, count, l);
    modport slave (input push_valid, push_id, replay_req, output busy, done, count, l);
endinterface

// File: rtl/mru_tick_gen.sv
// mru_tick_gen: free-running divider, one-cycle tick at count TICK_DIV-1 while enabled
module mru_tick_gen #(parameter int TICK_DIV = 25000000) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int TW = $clog2(TICK_DIV);
    logic [TW-1:0] cnt;
    assign tick = en && cnt == TW'(TICK_DIV - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mru_replay.sv
// mru_replay: move-to-front button history shown on LEDs, with paced playback.
// Define MRU_REPLAY_LOOP_EN for looping playback stopped by a new replay_req edge.
module mru_replay import mru_pkg::*; #(
    parameter int DEPTH = 3,
    parameter int TICK_DIV = 25000000
) (
    input logic clk,
    input logic rst,
    mru_replay_if.slave bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
`ifdef MRU_REPLAY_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    replay_state_t state;
    btn_id_t ent [DEPTH];
    btn_id_t lst [DEPTH];
    logic [DEPTH-1:0] vld, lvld;
    logic [CW-1:0] cnt, lcnt;
    logic [IW-1:0] idx, nidx;
    logic [MRU_NUM_BTN-1:0] idle_led, l_r;
    logic push_ok, hit, last, start, stop, tick, req_q, busy_r, done_r;
    // hit accumulates matches above slot i; slots at or above the match shift, below it stay
    always_comb begin
        push_ok = bus.push_valid && state == IDLE;
        hit = 1'b0;
        lst = ent;
        lvld = vld;
        for (int i = 1; i < DEPTH; i++) begin
            hit = hit | (vld[i-1] && ent[i-1] == bus.push_id);
            lst[i] = (push_ok && !hit) ? ent[i-1] : ent[i];
            lvld[i] = (push_ok && !hit) ? vld[i-1] : vld[i];
        end
        hit = hit | (vld[DEPTH-1] && ent[DEPTH-1] == bus.push_id);
        lst[0] = push_ok ? bus.push_id : ent[0];
        lvld[0] = push_ok | vld[0];
        lcnt = (!push_ok || hit || cnt == CW'(DEPTH)) ? cnt : cnt + 1'b1;
        idle_led = '0;
        for (int i = 0; i < DEPTH; i++) idle_led = idle_led | (lvld[i] ? id2led(lst[i]) : '0);
        last = CW'(idx) == cnt - 1'b1;
        nidx = last ? '0 : idx + 1'b1;
        start = state == IDLE && bus.replay_req && lcnt != '0;
        stop = LOOP && bus.replay_req && !req_q;
    end
    mru_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk(clk), .rst(rst), .en(state != IDLE), .clr(start), .tick(tick)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            vld <= '0;
            cnt <= '0;
            idx <= '0;
            l_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            req_q <= 1'b0;
        end else begin
            ent <= lst;
            vld <= lvld;
            cnt <= lcnt;
            req_q <= bus.replay_req;
            case (state)
                IDLE: begin
                    state <= !bus.replay_req ? IDLE : (lcnt != '0 ? SHOW : DONE);
                    idx <= '0;
                    l_r <= !bus.replay_req ? idle_led : (lcnt != '0 ? id2led(lst[0]) : '0);
                    busy_r <= bus.replay_req;
                    done_r <= bus.replay_req && lcnt == '0;
                end
                SHOW: begin
                    if (stop || (tick && last && !LOOP)) begin
                        state <= DONE;
                        done_r <= 1'b1;
                        l_r <= '0;
                    end else if (tick) begin
                        state <= GAP;
                        l_r <= '0;
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= DONE;
                        done_r <= 1'b1;
                    end else if (tick) begin
                        state <= SHOW;
                        idx <= nidx;
                        l_r <= id2led(ent[nidx]);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    l_r <= idle_led;
                end
            endcase
        end
    end
    assign bus.l = l_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.count = cnt;
endmodule

// File: doc/mru_replay.md
Name: mru_replay

Overview:
- Reader/consumer end of the button most-recently-used history.
- Accepts button-press events into a move-to-front MRU list of depth DEPTH.
- While idle, shows the list contents on the four LEDs.
- On request, plays the list back one LED at a time, most recent first, paced by an internal tick divider; sits between button conditioning and the LED outputs.

Parameters:
DEPTH, 3, number of MRU entries held (2..4)
TICK_DIV, 25000000, clk cycles per playback tick (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
push_valid  input  1  one-cycle strobe, a button press is present
push_id  input  2  pressed button, 0..3 = button 1..4
replay_req  input  1  level sampled each cycle; start playback when in IDLE
busy  output  1  high in SHOW/GAP/DONE
done  output  1  one-cycle pulse at end of playback
count  output  $clog2(DEPTH+1)  number of valid entries
l  output  4  LED drive, bit k = button k+1

Behaviour:
- Reset (rst=0, async): list cleared, count=0, state=IDLE, l=0, busy=0, done=0, tick counter=0.
- List: entry[0] is most recent, each entry has a valid bit.
- Push accepted only in IDLE:
  - id already present at position p: entries 0..p-1 shift down one, entry[0]=id, count unchanged.
  - id absent: all entries shift down, entry[0]=id, oldest dropped when full, count=min(count+1,DEPTH).
- Pushes in SHOW/GAP/DONE are ignored; the list is frozen during playback.
- IDLE LEDs: l = OR of onehot(entry) over valid entries. Registered: a push in cycle t is visible at t+1.
- FSM states IDLE, SHOW, GAP, DONE:
  - IDLE: replay_req=1 and count>0 -> SHOW, idx=0, tick counter restarted.
  - IDLE: replay_req=1 and count=0 -> DONE.
  - SHOW: l=onehot(entry[idx]) for exactly TICK_DIV cycles. Then, if idx=count-1 -> DONE, else -> GAP.
  - GAP: l=0 for TICK_DIV cycles, idx++ -> SHOW.
  - DONE: l=0, done=1 for one cycle -> IDLE.
- Same-cycle push_valid and replay_req in IDLE: the push is applied first and is included in the playback.
- Playback length from the replay_req sample edge: (2*count-1)*TICK_DIV cycles, then 1 DONE cycle.
- replay_req held high: playback restarts after each DONE (IDLE lasts one cycle between runs).
- Tick counter: 0..TICK_DIV-1 wrap, runs only when busy; zeroed on entry to SHOW from IDLE.
- Reset mid-playback: outputs clear immediately and the list is lost.
- push_id values are always legal (2-bit, all four codes used).

Optional Feature:
- Macro MRU_REPLAY_LOOP_EN.
- Defined:
  - after the last SHOW the FSM goes to GAP, then back to SHOW with idx=0, looping.
  - done does not pulse while looping.
  - A new rising edge of replay_req during playback -> DONE (pulse) -> IDLE.
- Undefined: single-pass behaviour as above; replay_req is ignored while busy.

Decomposition:
- Package mru_pkg holds:
  - btn_id_t (logic [1:0]).
  - replay_state_t enum {IDLE, SHOW, GAP, DONE}.
  - Function id2led (btn_id_t -> 4-bit onehot).
  - Constant MRU_NUM_BTN = 4.
- One sub-module, mru_tick_gen:
  - Parameter TICK_DIV; inputs clk, rst, en, clr; output tick, a one-cycle pulse at count TICK_DIV-1.
  - Reused by other LED-pacing blocks.

Test Plan:
- All scenarios use TICK_DIV=4, DEPTH=3.
- Reset then push ids 0,1,2 -> count=3, l=4'b0111, one cycle after each push l gains the new bit.
- With list {2,1,0}, push 0 -> list {0,2,1}, count=3, l=4'b0111. Push 3 -> list {3,0,2}, l=4'b1101 (button 2 dropped).
- List {3,0,2}, pulse replay_req -> l=1000 x4, 0000 x4, 0001 x4, 0000 x4, 0100 x4, then done=1 for 1 cycle, busy=0, l=1101.
- Replay with count=0 -> done pulses the next cycle, l stays 0, busy high for exactly 1 cycle.
- push_valid during SHOW -> list unchanged after DONE. Same-cycle push 1 + replay_req in IDLE -> first SHOW lights 0010.
- Assert rst=0 mid-GAP -> l=0, busy=0, count=0 with no clock edge. With MRU_REPLAY_LOOP_EN, 2-entry list loops until a replay_req edge ends it with a done pulse.
